sdram_rw_sched: RTL and testbench

Burst scheduler between the UART-side FIFOs and `sdram_ctrl`. It treats a fixed SDRAM window as a ring buffer. It issues fixed-length write bursts when the write FIFO holds a full burst and buffer space exists, and read bursts when the read FIFO has room and the buffer holds a full burst. Write and read access are shared round-robin. It owns the SDRAM write/read addresses and the stored-word count; `sdram_ctrl` stays address-agnostic.

---
 rtl/sdram_pkg.sv | 31 +++
 rtl/sdram_rw_sched_if.sv | 34 +++
 rtl/ring_ptr.sv | 34 +++
 rtl/sdram_rw_sched.sv | 183 ++++++++++++++++++
 tb/tb_sdram_rw_sched.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM burst path: address/length/count widths,
// default window geometry, the scheduler state encoding and a small
// saturating-increment helper used by the burst ack counter.
// No ports; imported by the scheduler, its pointer sub-module and the
// controller/FIFO wrappers that share these widths.
package sdram_pkg;

   localparam int ADDR_W = 24;
   localparam int LEN_W  = 10;
   localparam int CNT_W  = 25;

   localparam logic [ADDR_W-1:0] DEF_ADDR_BASE = 24'h000000;
   localparam logic [ADDR_W-1:0] DEF_DEPTH     = 24'd1024;
   localparam logic [LEN_W-1:0]  DEF_BURST_LEN = 10'd10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_WR_REQ,
      ST_WR_DATA,
      ST_RD_REQ,
      ST_RD_DATA
   } sched_state_t;

   // The ack counter is one bit wider than a burst length and saturates, so a
   // runaway ack stream can never wrap back around to a "correct" count.
   function automatic logic [LEN_W:0] ack_inc(input logic [LEN_W:0] cnt);
      return (&cnt) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/sdram_rw_sched_if.sv
// Burst request/ack bundle between the scheduler and sdram_ctrl.
// Signals:
//   sdram_wr_req / sdram_wr_addr / wr_burst_len : write burst request from scheduler
//   sdram_wr_ack                                : one pulse per write word accepted
//   sdram_rd_req / sdram_rd_addr / rd_burst_len : read burst request from scheduler
//   sdram_rd_ack                                : one pulse per read word returned
// Modports: master = scheduler side, slave = sdram_ctrl side.
interface sdram_rw_sched_if;

   logic                          sdram_wr_req;
   logic [sdram_pkg::ADDR_W-1:0]  sdram_wr_addr;
   logic [sdram_pkg::LEN_W-1:0]   wr_burst_len;
   logic                          sdram_wr_ack;

   logic                          sdram_rd_req;
   logic [sdram_pkg::ADDR_W-1:0]  sdram_rd_addr;
   logic [sdram_pkg::LEN_W-1:0]   rd_burst_len;
   logic                          sdram_rd_ack;

   modport master (
      output sdram_wr_req, sdram_wr_addr, wr_burst_len,
      input  sdram_wr_ack,
      output sdram_rd_req, sdram_rd_addr, rd_burst_len,
      input  sdram_rd_ack
   );

   modport slave (
      input  sdram_wr_req, sdram_wr_addr, wr_burst_len,
      output sdram_wr_ack,
      input  sdram_rd_req, sdram_rd_addr, rd_burst_len,
      output sdram_rd_ack
   );

endinterface

// File: rtl/ring_ptr.sv
// Ring-buffer word pointer: advances by STEP on request and wraps to 0 once
// it would reach DEPTH, so it always stays in 0..DEPTH-1.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (pointer clears to 0)
//   advance   : step the pointer by one burst this cycle
//   ptr       : current offset inside the window
module ring_ptr
   import sdram_pkg::*;
#(
   parameter logic [ADDR_W-1:0] DEPTH = DEF_DEPTH,
   parameter logic [LEN_W-1:0]  STEP  = DEF_BURST_LEN
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              advance,
   output logic [ADDR_W-1:0] ptr
);

   logic [ADDR_W:0] sum;

   // One spare bit keeps the sum from wrapping before it is compared
   // against the window size.
   assign sum = {1'b0, ptr} + (ADDR_W+1)'(STEP);

   // Pointer register; a step that lands on or past DEPTH restarts at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (sum >= {1'b0, DEPTH}) ? '0 : sum[ADDR_W-1:0];
      end
   end

endmodule

// File: rtl/sdram_rw_sched.sv
// Round-robin burst scheduler treating a fixed SDRAM window as a ring buffer.
// Write bursts move a full burst from the write FIFO into the window, read
// bursts move a full burst from the window into the read FIFO. The scheduler
// owns both ring pointers and the stored-word count; sdram_ctrl only sees
// start addresses.
// Ports:
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   init_end         : SDRAM init finished, sampled only while idle
//   wr_fifo_cnt      : words waiting in the write FIFO
//   rd_fifo_room     : free words in the read FIFO
//   rd_enable        : host allows draining the window
//   bus              : burst request/ack bundle to sdram_ctrl (master side)
//   stored_cnt       : words currently held in the window (0..DEPTH)
//   busy             : a burst is being requested or transferred
//   burst_err        : sticky, a burst saw an ack count other than BURST_LEN
module sdram_rw_sched
   import sdram_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDR_BASE = DEF_ADDR_BASE,
   parameter logic [ADDR_W-1:0] DEPTH     = DEF_DEPTH,
   parameter logic [LEN_W-1:0]  BURST_LEN = DEF_BURST_LEN
)(
   input  logic                    sys_clk,
   input  logic                    sys_rst,
   input  logic                    init_end,
   input  logic [LEN_W-1:0]        wr_fifo_cnt,
   input  logic [LEN_W-1:0]        rd_fifo_room,
   input  logic                    rd_enable,
   sdram_rw_sched_if.master        bus,
   output logic [CNT_W-1:0]        stored_cnt,
   output logic                    busy,
   output logic                    burst_err
);

   localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] WR_LIMIT  = DEPTH_CNT - BURST_CNT;

   sched_state_t      state;
   logic              last_wr;
   logic [LEN_W:0]    ack_cnt;
   logic              wr_req;
   logic              rd_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic              wr_ok;
   logic              rd_ok;
   logic              wr_done;
   logic              rd_done;

   // Burst lengths never change; requests and addresses come from flops.
   assign bus.wr_burst_len  = BURST_LEN;
   assign bus.rd_burst_len  = BURST_LEN;
   assign bus.sdram_wr_req  = wr_req;
   assign bus.sdram_rd_req  = rd_req;
   assign bus.sdram_wr_addr = wr_addr;
   assign bus.sdram_rd_addr = rd_addr;

   // Eligibility only matters in ARB. A write needs a whole burst waiting and
   // a whole burst of free window; a read needs permission, FIFO room and a
   // whole burst already stored. Full and empty both leave the pointers
   // equal, so stored_cnt is what tells them apart.
   assign wr_ok = (wr_fifo_cnt >= BURST_LEN) && (stored_cnt <= WR_LIMIT);
   assign rd_ok = rd_enable && (rd_fifo_room >= BURST_LEN) && (stored_cnt >= BURST_CNT);

   // A burst is finished on the first ack-low cycle of its data phase; that
   // same edge moves the matching pointer on.
   assign wr_done = (state == ST_WR_DATA) && !bus.sdram_wr_ack;
   assign rd_done = (state == ST_RD_DATA) && !bus.sdram_rd_ack;

   ring_ptr #(.DEPTH(DEPTH), .STEP(BURST_LEN)) u_wr_ptr (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .advance (wr_done),
      .ptr     (wr_ptr)
   );

   ring_ptr #(.DEPTH(DEPTH), .STEP(BURST_LEN)) u_rd_ptr (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .advance (rd_done),
      .ptr     (rd_ptr)
   );

   // Main scheduler FSM. Requests, addresses and busy are all registered here
   // so sdram_ctrl sees clean levels. On a tie the side not served last time
   // wins; last_wr resets to "read" so the first tie goes to the write side.
   // The ack counter starts at 1 because the ack that ends the request phase
   // already carried the first word. A reset mid-burst simply drops the
   // burst, since sdram_ctrl is reset alongside.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         last_wr    <= 1'b0;
         ack_cnt    <= '0;
         wr_req     <= 1'b0;
         rd_req     <= 1'b0;
         wr_addr    <= ADDR_BASE;
         rd_addr    <= ADDR_BASE;
         stored_cnt <= '0;
         busy       <= 1'b0;
         burst_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (init_end) begin
                  state <= ST_ARB;
               end
            end

            ST_ARB: begin
               if (wr_ok && (!rd_ok || !last_wr)) begin
                  state   <= ST_WR_REQ;
                  wr_req  <= 1'b1;
                  wr_addr <= ADDR_BASE + wr_ptr;
                  last_wr <= 1'b1;
                  busy    <= 1'b1;
                  ack_cnt <= '0;
               end else if (rd_ok) begin
                  state   <= ST_RD_REQ;
                  rd_req  <= 1'b1;
                  rd_addr <= ADDR_BASE + rd_ptr;
                  last_wr <= 1'b0;
                  busy    <= 1'b1;
                  ack_cnt <= '0;
               end
            end

            ST_WR_REQ: begin
               if (bus.sdram_wr_ack) begin
                  wr_req  <= 1'b0;
                  ack_cnt <= (LEN_W+1)'(1);
                  state   <= ST_WR_DATA;
               end
            end

            ST_WR_DATA: begin
               if (bus.sdram_wr_ack) begin
                  ack_cnt <= ack_inc(ack_cnt);
               end else begin
                  stored_cnt <= stored_cnt + BURST_CNT;
                  if (ack_cnt != {1'b0, BURST_LEN}) begin
                     burst_err <= 1'b1;
                  end
                  busy  <= 1'b0;
                  state <= ST_ARB;
               end
            end

            ST_RD_REQ: begin
               if (bus.sdram_rd_ack) begin
                  rd_req  <= 1'b0;
                  ack_cnt <= (LEN_W+1)'(1);
                  state   <= ST_RD_DATA;
               end
            end

            ST_RD_DATA: begin
               if (bus.sdram_rd_ack) begin
                  ack_cnt <= ack_inc(ack_cnt);
               end else begin
                  stored_cnt <= stored_cnt - BURST_CNT;
                  if (ack_cnt != {1'b0, BURST_LEN}) begin
                     burst_err <= 1'b1;
                  end
                  busy  <= 1'b0;
                  state <= ST_ARB;
               end
            end

            default: begin
               state  <= ST_IDLE;
               wr_req <= 1'b0;
               rd_req <= 1'b0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_rw_sched.sv
// Self-checking bench for sdram_rw_sched using a small 20-word window placed
// just below the top of the 24-bit address space, so burst addresses also
// exercise the no-carry wrap. A behavioural model (word count, two ring
// offsets, last grant, sticky error) predicts every grant, address and count.
module tb_sdram_rw_sched;

   localparam logic [23:0] BASE    = 24'hFFFFF6;
   localparam int          DEPTH_W = 20;
   localparam int          BL      = 10;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        init_end;
   logic [9:0]  wr_fifo_cnt;
   logic [9:0]  rd_fifo_room;
   logic        rd_enable;
   logic [24:0] stored_cnt;
   logic        busy;
   logic        burst_err;

   sdram_rw_sched_if bus();

   sdram_rw_sched #(
      .ADDR_BASE (BASE),
      .DEPTH     (24'(DEPTH_W)),
      .BURST_LEN (10'(BL))
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .init_end     (init_end),
      .wr_fifo_cnt  (wr_fifo_cnt),
      .rd_fifo_room (rd_fifo_room),
      .rd_enable    (rd_enable),
      .bus          (bus),
      .stored_cnt   (stored_cnt),
      .busy         (busy),
      .burst_err    (burst_err)
   );

   // 100 MHz clock
   always #5 sys_clk = ~sys_clk;

   int checkCnt = 0;
   int passCnt  = 0;
   int failCnt  = 0;
   bit monitorOn = 1'b0;

   // Reference model state
   int mStored;
   int mWrPtr;
   int mRdPtr;
   bit mLastWr;
   bit mErr;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCnt++;
      assert (obs === exp) passCnt++;
      else begin
         failCnt++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input int wfc, input int room, input bit en);
      wr_fifo_cnt  = 10'(wfc);
      rd_fifo_room = 10'(room);
      rd_enable    = en;
   endtask

   task automatic modelReset();
      mStored = 0;
      mWrPtr  = 0;
      mRdPtr  = 0;
      mLastWr = 1'b0;
      mErr    = 1'b0;
   endtask

   // Both requests high at once is never legal.
   always @(negedge sys_clk) begin
      if (monitorOn) begin
         checkOutput("req_mutex", {31'b0, bus.sdram_wr_req & bus.sdram_rd_req}, 32'd0);
      end
   end

   // Called at a negedge with the DUT sitting in arbitration. Predicts the
   // grant from the model, services the burst with nack acks after ackDelay
   // idle cycles, and checks the bookkeeping afterwards. With nothing
   // eligible it watches for watch cycles that no request appears.
   task automatic doStep(input int nack, input int ackDelay, input int watch);
      bit wrOk;
      bit rdOk;
      bit grantWr;
      bit seen;
      int expAddr;
      wrOk = (int'(wr_fifo_cnt) >= BL) && (mStored + BL <= DEPTH_W);
      rdOk = rd_enable && (int'(rd_fifo_room) >= BL) && (mStored >= BL);
      if (!wrOk && !rdOk) begin
         seen = 1'b0;
         repeat (watch) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (bus.sdram_wr_req || bus.sdram_rd_req) seen = 1'b1;
         end
         checkOutput("no_grant", {31'b0, seen}, 32'd0);
         return;
      end
      grantWr = wrOk && (!rdOk || !mLastWr);
      expAddr = grantWr ? mWrPtr : mRdPtr;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("wr_req", {31'b0, bus.sdram_wr_req}, {31'b0, grantWr});
      checkOutput("rd_req", {31'b0, bus.sdram_rd_req}, {31'b0, !grantWr});
      checkOutput(grantWr ? "wr_addr" : "rd_addr",
                  {8'b0, grantWr ? bus.sdram_wr_addr : bus.sdram_rd_addr},
                  {8'b0, 24'(int'(BASE) + expAddr)});
      checkOutput("busy_req", {31'b0, busy}, 32'd1);
      if (ackDelay > 0) begin
         repeat (ackDelay) begin
            @(posedge sys_clk);
            @(negedge sys_clk);
         end
         checkOutput("req_hold", {31'b0, bus.sdram_wr_req | bus.sdram_rd_req}, 32'd1);
      end
      if (grantWr) bus.sdram_wr_ack = 1'b1;
      else         bus.sdram_rd_ack = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("req_drop", {31'b0, bus.sdram_wr_req | bus.sdram_rd_req}, 32'd0);
      for (int i = 1; i < nack; i++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_rd_ack = 1'b0;
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (grantWr) begin
         mStored = mStored + BL;
         mWrPtr  = (mWrPtr + BL) % DEPTH_W;
         mLastWr = 1'b1;
      end else begin
         mStored = mStored - BL;
         mRdPtr  = (mRdPtr + BL) % DEPTH_W;
         mLastWr = 1'b0;
      end
      if (nack != BL) mErr = 1'b1;
      checkOutput("stored_cnt", {7'b0, stored_cnt}, 32'(mStored));
      checkOutput("burst_err", {31'b0, burst_err}, {31'b0, mErr});
      checkOutput("busy_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int nack;
      bit seen;
      sys_rst          = 1'b1;
      init_end         = 1'b0;
      bus.sdram_wr_ack = 1'b0;
      bus.sdram_rd_ack = 1'b0;
      applyStimulus(10, 0, 1'b0);
      modelReset();

      // Reset held with init_end pulsed: everything at reset values.
      @(negedge sys_clk);
      monitorOn = 1'b1;
      init_end = 1'b1;
      @(negedge sys_clk);
      init_end = 1'b0;
      @(negedge sys_clk);
      checkOutput("rst_wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);
      checkOutput("rst_rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
      checkOutput("rst_wr_addr", {8'b0, bus.sdram_wr_addr}, {8'b0, BASE});
      checkOutput("rst_rd_addr", {8'b0, bus.sdram_rd_addr}, {8'b0, BASE});
      checkOutput("rst_stored", {7'b0, stored_cnt}, 32'd0);
      checkOutput("rst_busy", {31'b0, busy}, 32'd0);
      checkOutput("rst_err", {31'b0, burst_err}, 32'd0);
      checkOutput("wr_len", {22'b0, bus.wr_burst_len}, 32'(BL));
      checkOutput("rd_len", {22'b0, bus.rd_burst_len}, 32'(BL));

      // Out of reset but init_end low: nothing may be issued.
      sys_rst = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         if (bus.sdram_wr_req || bus.sdram_rd_req) seen = 1'b1;
      end
      checkOutput("idle_no_req", {31'b0, seen}, 32'd0);

      // init_end rises: one cycle into ARB, then the first write burst.
      $display("[TB] first write after init");
      init_end = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("arb_no_req_yet", {31'b0, bus.sdram_wr_req}, 32'd0);
      doStep(BL, 0, 20);

      // Both sides eligible: grants alternate.
      $display("[TB] alternating read/write");
      applyStimulus(10, 10, 1'b1);
      repeat (4) doStep(BL, 1, 20);

      // Short ack stream sets the sticky error; a good burst leaves it set.
      $display("[TB] short burst error");
      doStep(BL - 1, 0, 20);
      doStep(BL, 2, 20);
      doStep(BL, 0, 20);

      // Fill the window with reads disabled, then confirm writes are withheld.
      $display("[TB] fill and drain with wrap");
      applyStimulus(10, 10, 1'b0);
      for (int i = 0; i < 3 && mStored < DEPTH_W; i++) doStep(BL, 0, 20);
      checkOutput("full_stored", {7'b0, stored_cnt}, 32'(DEPTH_W));
      doStep(BL, 0, 30);
      applyStimulus(0, 10, 1'b1);
      doStep(BL, 0, 20);
      doStep(BL, 3, 20);
      checkOutput("empty_stored", {7'b0, stored_cnt}, 32'd0);
      doStep(BL, 0, 30);

      // Empty window, and later insufficient FIFO room: no read for 1000 cycles.
      doStep(BL, 0, 1000);
      applyStimulus(10, 9, 1'b1);
      doStep(BL, 0, 20);
      applyStimulus(0, 9, 1'b1);
      doStep(BL, 0, 1000);

      // Randomized traffic against the model.
      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom_range(0, 20), $urandom_range(5, 30), ($urandom_range(0, 3) != 0));
         nack = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 11)) : BL;
         doStep(nack, $urandom_range(0, 3), 10);
      end

      // Steer the write pointer to a nonzero offset with room for one burst.
      for (int i = 0; i < 4 && mWrPtr != BL; i++) begin
         if (mStored == DEPTH_W) begin
            applyStimulus(0, 10, 1'b1);
            doStep(BL, 0, 20);
         end
         applyStimulus(10, 0, 1'b0);
         doStep(BL, 0, 20);
      end
      if (mStored == DEPTH_W) begin
         applyStimulus(0, 10, 1'b1);
         doStep(BL, 0, 20);
      end

      // Reset in the middle of a write data phase.
      $display("[TB] reset mid burst");
      applyStimulus(10, 0, 1'b0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("mid_wr_req", {31'b0, bus.sdram_wr_req}, 32'd1);
      checkOutput("mid_wr_addr", {8'b0, bus.sdram_wr_addr}, {8'b0, 24'(int'(BASE) + mWrPtr)});
      bus.sdram_wr_ack = 1'b1;
      repeat (4) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
      end
      checkOutput("mid_busy", {31'b0, busy}, 32'd1);
      sys_rst = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      checkOutput("mrst_wr_req", {31'b0, bus.sdram_wr_req}, 32'd0);
      checkOutput("mrst_rd_req", {31'b0, bus.sdram_rd_req}, 32'd0);
      checkOutput("mrst_stored", {7'b0, stored_cnt}, 32'd0);
      checkOutput("mrst_busy", {31'b0, busy}, 32'd0);
      checkOutput("mrst_err", {31'b0, burst_err}, 32'd0);
      checkOutput("mrst_wr_addr", {8'b0, bus.sdram_wr_addr}, {8'b0, BASE});
      checkOutput("mrst_rd_addr", {8'b0, bus.sdram_rd_addr}, {8'b0, BASE});
      bus.sdram_wr_ack = 1'b0;
      sys_rst = 1'b0;
      modelReset();
      @(posedge sys_clk);
      @(negedge sys_clk);

      // Pointers restart at the window base after reset.
      doStep(BL, 0, 20);
      applyStimulus(0, 10, 1'b1);
      doStep(BL, 0, 20);

      monitorOn = 1'b0;
      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
